deadlock_report_arbiter: RTL and testbench

DEADLOCK_REPORT_ARBITER -- requirements
Module: deadlock_report_arbiter

---
 rtl/deadlock_report_arbiter.sv | 137 +++++++++++++
 tb/tb_deadlock_report_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/deadlock_report_arbiter.sv
// Deadlock report arbiter: confirms persistent monitor blocks, timestamps
// them and serialises reports to one consumer with round-robin fairness.
module deadlock_report_arbiter #(
    parameter int NUM_MON = 4,
    parameter int PERSIST = 16,
    parameter int ID_W    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
    input  logic [NUM_MON-1:0]  clear_sticky,
    input  logic                rpt_ready,
    output logic                rpt_valid,
    output logic [ID_W-1:0]     rpt_id,
    output logic [15:0]         rpt_stamp,
    output logic [NUM_MON-1:0]  seen,
    output logic [NUM_MON-1:0]  ovf,
    output logic                irq
);

    typedef enum logic {IDLE, REPORT} state_t;

    localparam logic [15:0] PMAX = 16'(PERSIST);
    localparam logic [15:0] PM1  = 16'(PERSIST - 1);

    state_t              state_q;
    logic [15:0]         ts_q;
    logic [15:0]         cnt_q   [NUM_MON];
    logic [15:0]         stamp_q [NUM_MON];
    logic [NUM_MON-1:0]  pend_q, pend_d;
    logic [NUM_MON-1:0]  seen_q, seen_d;
    logic [NUM_MON-1:0]  ovf_q, ovf_d;
    logic [ID_W-1:0]     last_q;
    logic                rpt_valid_q;
    logic [ID_W-1:0]     rpt_id_q;
    logic [15:0]         rpt_stamp_q;
    logic                irq_q;

    logic [NUM_MON-1:0]  confirm, hs_clr, held;
    logic                hs;
    logic                gnt_found;
    int                  gnt_idx;
    int                  idx;

    always_comb begin
        for (int i = 0; i < NUM_MON; i++)
            confirm[i] = mon_block[i] && (cnt_q[i] == PM1);
        hs     = rpt_valid_q && rpt_ready;
        hs_clr = hs ? (NUM_MON'(1) << rpt_id_q) : '0;
        // A confirm on the handshake edge re-arms pending rather than overflowing
        held   = pend_q & ~hs_clr;
        pend_d = held | confirm;
        seen_d = (seen_q & ~clear_sticky) | confirm;
        ovf_d  = (ovf_q & ~clear_sticky) | (confirm & held);
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 0;
        idx       = 0;
        for (int j = 1; j <= NUM_MON; j++) begin
            idx = (int'(last_q) + j) % NUM_MON;
            if (!gnt_found && pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q   <= '0;
            pend_q <= '0;
            seen_q <= '0;
            ovf_q  <= '0;
            irq_q  <= 1'b0;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt_q[i]   <= '0;
                stamp_q[i] <= '0;
            end
        end else begin
            ts_q   <= ts_q + 16'd1;
            pend_q <= pend_d;
            seen_q <= seen_d;
            ovf_q  <= ovf_d;
            irq_q  <= |seen_q;
            for (int i = 0; i < NUM_MON; i++) begin
                if (!mon_block[i])
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != PMAX)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                if (confirm[i] && !held[i])
                    stamp_q[i] <= ts_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rpt_valid_q <= 1'b0;
            rpt_id_q    <= '0;
            rpt_stamp_q <= '0;
            last_q      <= ID_W'(NUM_MON - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        state_q     <= REPORT;
                        rpt_valid_q <= 1'b1;
                        rpt_id_q    <= ID_W'(gnt_idx);
                        rpt_stamp_q <= stamp_q[gnt_idx];
                        last_q      <= ID_W'(gnt_idx);
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        state_q     <= IDLE;
                        rpt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rpt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_id    = rpt_id_q;
    assign rpt_stamp = rpt_stamp_q;
    assign seen      = seen_q;
    assign ovf       = ovf_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_deadlock_report_arbiter.sv
// Scoreboard bench: stimulus pushes expected reports, a negedge monitor
// pops and compares them at each handshake.
module tb_deadlock_report_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  mon_block;
    logic [3:0]  clear_sticky;
    logic        rpt_ready;
    logic        rpt_valid;
    logic [3:0]  rpt_id;
    logic [15:0] rpt_stamp;
    logic [3:0]  seen;
    logic [3:0]  ovf;
    logic        irq;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] st;
    } rpt_t;

    rpt_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] tsm;
    logic        prev_hs;
    logic [15:0] t;

    deadlock_report_arbiter #(.NUM_MON(4), .PERSIST(16), .ID_W(4)) dut (
        .clock(clock), .reset(reset), .mon_block(mon_block),
        .clear_sticky(clear_sticky), .rpt_ready(rpt_ready),
        .rpt_valid(rpt_valid), .rpt_id(rpt_id), .rpt_stamp(rpt_stamp),
        .seen(seen), .ovf(ovf), .irq(irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tsm <= reset ? 16'd0 : tsm + 16'd1;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic push(input logic [3:0] id, input logic [15:0] st);
        rpt_t r;
        r.id = id;
        r.st = st;
        sb.push_back(r);
    endtask

    always @(negedge clock) begin
        rpt_t r;
        if (reset) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("idle_gap", {31'd0, rpt_valid}, 32'd0);
            prev_hs = rpt_valid && rpt_ready;
            if (rpt_valid && rpt_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report: id=%0d stamp=%0d want=none",
                             rpt_id, rpt_stamp);
                end else begin
                    r = sb.pop_front();
                    chk("rpt_id", {28'd0, rpt_id}, {28'd0, r.id});
                    chk("rpt_stamp", {16'd0, rpt_stamp}, {16'd0, r.st});
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mon_block = '0;
        clear_sticky = '0;
        rpt_ready = 1'b1;
        prev_hs = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, rpt_valid}, 0);
        chk("rst_id", {28'd0, rpt_id}, 0);
        chk("rst_stamp", {16'd0, rpt_stamp}, 0);
        chk("rst_seen", {28'd0, seen}, 0);
        chk("rst_ovf", {28'd0, ovf}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        reset = 1'b0;

        // Basic latency: mon 2 high 16 edges from edge 10
        tick(10);
        mon_block = 4'b0100;
        push(4'd2, 16'd25);
        tick(16);
        mon_block = '0;
        chk("lat_seen", {28'd0, seen}, 32'h4);
        chk("lat_valid_early", {31'd0, rpt_valid}, 0);
        chk("lat_irq_early", {31'd0, irq}, 0);
        tick(1);
        chk("lat_valid", {31'd0, rpt_valid}, 1);
        chk("lat_id", {28'd0, rpt_id}, 2);
        tick(1);
        chk("lat_irq", {31'd0, irq}, 1);

        // Short episodes never confirm
        clear_sticky = 4'hF;
        tick(1);
        clear_sticky = '0;
        chk("clr_seen", {28'd0, seen}, 0);
        for (int k = 0; k < 3; k++) begin
            mon_block = 4'b0010;
            tick(15);
            mon_block = '0;
            tick(1);
        end
        tick(2);
        chk("short_seen", {28'd0, seen}, 0);
        chk("short_valid", {31'd0, rpt_valid}, 0);

        // Simultaneous confirms, round-robin from fresh reset
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        t = tsm;
        mon_block = 4'b1011;
        push(4'd0, t + 16'd15);
        push(4'd1, t + 16'd15);
        push(4'd3, t + 16'd15);
        tick(16);
        mon_block = '0;
        chk("rr_seen", {28'd0, seen}, 32'hB);
        tick(8);
        t = tsm;
        mon_block = 4'b1001;
        push(4'd0, t + 16'd15);
        push(4'd3, t + 16'd15);
        tick(16);
        mon_block = '0;
        tick(6);
        chk("rr_drained", sb.size(), 0);

        // Overflow while pending and consumer stalled
        clear_sticky = 4'hF;
        rpt_ready = 1'b0;
        tick(1);
        clear_sticky = '0;
        t = tsm;
        mon_block = 4'b0100;
        push(4'd2, t + 16'd15);
        tick(16);
        mon_block = '0;
        tick(1);
        mon_block = 4'b0100;
        tick(16);
        mon_block = '0;
        chk("ovf_set", {28'd0, ovf}, 32'h4);
        chk("ovf_valid", {31'd0, rpt_valid}, 1);
        chk("ovf_id", {28'd0, rpt_id}, 2);
        chk("ovf_stamp_held", {16'd0, rpt_stamp}, {16'd0, t + 16'd15});
        rpt_ready = 1'b1;
        tick(5);
        chk("ovf_single", {31'd0, rpt_valid}, 0);

        // Clear coinciding with a set keeps the bit
        clear_sticky = 4'hF;
        tick(1);
        clear_sticky = '0;
        chk("clr2_seen", {28'd0, seen}, 0);
        chk("clr2_ovf", {28'd0, ovf}, 0);
        t = tsm;
        mon_block = 4'b0100;
        push(4'd2, t + 16'd15);
        tick(15);
        clear_sticky = 4'b0100;
        tick(1);
        clear_sticky = '0;
        mon_block = '0;
        chk("set_wins", {28'd0, seen}, 32'h4);
        tick(4);
        clear_sticky = 4'b0100;
        tick(1);
        clear_sticky = '0;
        chk("clr_alone", {28'd0, seen}, 0);
        chk("irq_lag", {31'd0, irq}, 1);
        tick(1);
        chk("irq_off", {31'd0, irq}, 0);

        // Reset aborts an active report
        rpt_ready = 1'b0;
        mon_block = 4'b0001;
        for (int k = 0; k < 40 && !rpt_valid; k++) tick(1);
        chk("abort_valid_seen", {31'd0, rpt_valid}, 1);
        reset = 1'b1;
        tick(1);
        sb.delete();
        chk("abort_valid", {31'd0, rpt_valid}, 0);
        chk("abort_seen", {28'd0, seen}, 0);
        chk("abort_ovf", {28'd0, ovf}, 0);
        chk("abort_irq", {31'd0, irq}, 0);
        chk("abort_stamp", {16'd0, rpt_stamp}, 0);
        tick(1);
        reset = 1'b0;
        rpt_ready = 1'b1;
        push(4'd0, 16'd15);
        tick(16);
        chk("fresh_valid_early", {31'd0, rpt_valid}, 0);
        tick(1);
        chk("fresh_valid", {31'd0, rpt_valid}, 1);
        tick(3);
        mon_block = '0;
        tick(3);
        chk("final_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
